// File: rtl/descrambler_lock_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : descrambler_lock_ctrl_if
//  Purpose  : Control/status bundle between the lock sequencer and the
//             descrambler bank / deskew logic.
//  Revision : 1.0  initial release
// ============================================================================
interface descrambler_lock_ctrl_if #(
    parameter int NUM_LANES = 4
);
    logic                     ENABLE;
    logic [NUM_LANES-1:0]     LANE_MASK;
    logic                     RETRY_ALL;
    logic                     CLEAR_STATS;
    logic [NUM_LANES-1:0]     LANE_VALID;
    logic [NUM_LANES-1:0]     LANE_LOCKED;
    logic [NUM_LANES-1:0]     LANE_RESET;
    logic [NUM_LANES-1:0]     LANE_UP;
    logic [NUM_LANES-1:0]     LANE_FAILED;
    logic                     ALL_LOCKED;
    logic                     ANY_FAILED;
    logic [8*NUM_LANES-1:0]   LOSS_COUNT;

    modport master (
        output ENABLE, LANE_MASK, RETRY_ALL, CLEAR_STATS, LANE_VALID, LANE_LOCKED,
        input  LANE_RESET, LANE_UP, LANE_FAILED, ALL_LOCKED, ANY_FAILED, LOSS_COUNT
    );

    modport slave (
        input  ENABLE, LANE_MASK, RETRY_ALL, CLEAR_STATS, LANE_VALID, LANE_LOCKED,
        output LANE_RESET, LANE_UP, LANE_FAILED, ALL_LOCKED, ANY_FAILED, LOSS_COUNT
    );
endinterface
`default_nettype wire

// File: rtl/descrambler_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : descrambler_lock_ctrl
//  Purpose  : Per-lane descrambler reset/hunt/retry sequencer with aggregate
//             lock and failure status for the RX alignment stage.
//  Revision : 1.0  initial release
// ============================================================================
module descrambler_lock_ctrl #(
    parameter int NUM_LANES    = 4,
    parameter int LOCK_TIMEOUT = 256,
    parameter int RESET_CYCLES = 4,
    parameter int MAX_RETRIES  = 3
) (
    input wire                      USER_CLK,
    input wire                      SYSTEM_RESET_N,
    descrambler_lock_ctrl_if.slave  bus
);

    localparam int c_RW = $clog2(RESET_CYCLES + 1);
    localparam int c_HW = $clog2(LOCK_TIMEOUT + 1);
    localparam int c_TW = $clog2(MAX_RETRIES + 1);

    localparam logic [c_RW-1:0] c_RST_LAST  = c_RW'(RESET_CYCLES - 1);
    localparam logic [c_HW-1:0] c_HUNT_LAST = c_HW'(LOCK_TIMEOUT - 1);
    localparam logic [c_TW-1:0] c_RETRY_MAX = c_TW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_DISABLED = 3'd0,
        ST_RESET    = 3'd1,
        ST_HUNT     = 3'd2,
        ST_LOCKED   = 3'd3,
        ST_FAILED   = 3'd4
    } lane_state_t;

    logic [NUM_LANES-1:0]   r_lane_en;
    logic [NUM_LANES-1:0]   w_lane_reset;
    logic [NUM_LANES-1:0]   w_lane_up;
    logic [NUM_LANES-1:0]   w_lane_failed;
    logic [8*NUM_LANES-1:0] w_loss_count;

    // Registered copy of the lane enables, so ALL_LOCKED tracks the same edge as the lane FSMs
    always_ff @(posedge USER_CLK) begin
        if (!SYSTEM_RESET_N) begin
            r_lane_en <= '0;
        end else begin
            r_lane_en <= bus.ENABLE ? bus.LANE_MASK : '0;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_state_t     r_state;
        logic [c_RW-1:0] r_rst_ctr;
        logic [c_HW-1:0] r_hunt_ctr;
        logic [c_TW-1:0] r_retry_ctr;
        logic [7:0]      r_loss_ctr;
        logic            r_lane_reset;
        logic            r_lane_up;
        logic            r_lane_failed;
        logic            w_en;

        assign w_en = bus.ENABLE & bus.LANE_MASK[i];

        always_ff @(posedge USER_CLK) begin
            if (!SYSTEM_RESET_N) begin
                r_state       <= ST_DISABLED;
                r_rst_ctr     <= '0;
                r_hunt_ctr    <= '0;
                r_retry_ctr   <= '0;
                r_loss_ctr    <= '0;
                r_lane_reset  <= 1'b1;
                r_lane_up     <= 1'b0;
                r_lane_failed <= 1'b0;
            end else begin
                if (bus.CLEAR_STATS) begin
                    r_loss_ctr <= '0;
                end
                if (!w_en) begin
                    r_state       <= ST_DISABLED;
                    r_retry_ctr   <= '0;
                    r_lane_reset  <= 1'b1;
                    r_lane_up     <= 1'b0;
                    r_lane_failed <= 1'b0;
                end else begin
                    case (r_state)
                        ST_DISABLED: begin
                            r_state   <= ST_RESET;
                            r_rst_ctr <= '0;
                        end
                        ST_RESET: begin
                            r_rst_ctr <= r_rst_ctr + 1'b1;
                            if (r_rst_ctr == c_RST_LAST) begin
                                r_state      <= ST_HUNT;
                                r_hunt_ctr   <= '0;
                                r_lane_reset <= 1'b0;
                            end
                        end
                        ST_HUNT: begin
                            if (bus.LANE_VALID[i]) begin
                                r_hunt_ctr <= r_hunt_ctr + 1'b1;
                            end
                            // A lock seen on the timeout word still counts as success
                            if (bus.LANE_LOCKED[i]) begin
                                r_state     <= ST_LOCKED;
                                r_retry_ctr <= '0;
                                r_lane_up   <= 1'b1;
                            end else if (bus.LANE_VALID[i] && r_hunt_ctr == c_HUNT_LAST) begin
                                r_lane_reset <= 1'b1;
                                if (r_retry_ctr == c_RETRY_MAX) begin
                                    r_state       <= ST_FAILED;
                                    r_lane_failed <= 1'b1;
                                end else begin
                                    r_state     <= ST_RESET;
                                    r_rst_ctr   <= '0;
                                    r_retry_ctr <= r_retry_ctr + 1'b1;
                                end
                            end
                        end
                        ST_LOCKED: begin
                            if (!bus.LANE_LOCKED[i]) begin
                                r_state      <= ST_RESET;
                                r_rst_ctr    <= '0;
                                r_retry_ctr  <= '0;
                                r_lane_reset <= 1'b1;
                                r_lane_up    <= 1'b0;
                                // Clear-then-count when a loss coincides with CLEAR_STATS
                                if (bus.CLEAR_STATS) begin
                                    r_loss_ctr <= 8'd1;
                                end else if (r_loss_ctr != 8'hFF) begin
                                    r_loss_ctr <= r_loss_ctr + 8'd1;
                                end
                            end
                        end
                        ST_FAILED: begin
                            if (bus.RETRY_ALL) begin
                                r_state       <= ST_RESET;
                                r_rst_ctr     <= '0;
                                r_retry_ctr   <= '0;
                                r_lane_failed <= 1'b0;
                            end
                        end
                        default: begin
                            r_state       <= ST_DISABLED;
                            r_lane_reset  <= 1'b1;
                            r_lane_up     <= 1'b0;
                            r_lane_failed <= 1'b0;
                        end
                    endcase
                end
            end
        end

        assign w_lane_reset[i]           = r_lane_reset;
        assign w_lane_up[i]              = r_lane_up;
        assign w_lane_failed[i]          = r_lane_failed;
        assign w_loss_count[8*i +: 8]    = r_loss_ctr;
    end

    assign bus.LANE_RESET  = w_lane_reset;
    assign bus.LANE_UP     = w_lane_up;
    assign bus.LANE_FAILED = w_lane_failed;
    assign bus.LOSS_COUNT  = w_loss_count;
    assign bus.ALL_LOCKED  = (|r_lane_en) & (&(w_lane_up | ~r_lane_en));
    assign bus.ANY_FAILED  = |w_lane_failed;

endmodule
`default_nettype wire
